// File: rtl/stepmotor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stepmotor_pkg : direction codes, FSM states, error codes, default dwells |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package stepmotor_pkg;

   localparam int               DWELL_W   = 6;
   localparam logic [DWELL_W-1:0] DWELL_MAX = 6'd63;

   localparam int DEF_TIME_FWD  = 30;
   localparam int DEF_TIME_STOP = 10;
   localparam int DEF_TIME_REV  = 30;
   localparam int DEF_TOL       = 0;

   localparam logic [5:0] DIR_FWD  = 6'b000111;
   localparam logic [5:0] DIR_STOP = 6'b000000;
   localparam logic [5:0] DIR_REV  = 6'b111000;

   typedef enum logic [1:0] {
      CODE_STOP = 2'd0,
      CODE_FWD  = 2'd1,
      CODE_REV  = 2'd2,
      CODE_ILL  = 2'd3
   } code_t;

   typedef enum logic [2:0] {
      ST_SYNC    = 3'd0,
      ST_FWD     = 3'd1,
      ST_STOP_AF = 3'd2,
      ST_REV     = 3'd3,
      ST_STOP_AR = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

   localparam logic [1:0] MODE_SYNC = 2'b00;
   localparam logic [1:0] MODE_FWD  = 2'b01;
   localparam logic [1:0] MODE_STOP = 2'b10;
   localparam logic [1:0] MODE_REV  = 2'b11;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_DURATION = 3'd1;
   localparam logic [2:0] ERR_ORDER    = 3'd2;
   localparam logic [2:0] ERR_ILLEGAL  = 3'd3;
   localparam logic [2:0] ERR_OVERRUN  = 3'd4;

   function automatic code_t decode_dir(input logic [5:0] d);
      case (d)
         DIR_FWD:  return CODE_FWD;
         DIR_STOP: return CODE_STOP;
         DIR_REV:  return CODE_REV;
         default:  return CODE_ILL;
      endcase
   endfunction

   // Only meaningful for the four checking states.
   function automatic code_t expected_next(input state_t s);
      case (s)
         ST_FWD:     return CODE_STOP;
         ST_STOP_AF: return CODE_REV;
         ST_REV:     return CODE_STOP;
         default:    return CODE_FWD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/stepmotor_dwell_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stepmotor_dwell_cnt : saturating dwell counter, loads 1 on code change   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stepmotor_dwell_cnt
   import stepmotor_pkg::*;
(
   input  logic               clk1h,
   input  logic               rst,
   input  logic               load,
   output logic [DWELL_W-1:0] dwell
);

   always_ff @(posedge clk1h or negedge rst) begin
      if (!rst) begin
         dwell <= '0;
      end else if (load) begin
         dwell <= 6'd1;
      end else if (dwell != DWELL_MAX) begin
         dwell <= dwell + 6'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stepmotor_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stepmotor_monitor : checks fwd-stop-rev-stop order and dwell timing      |
// | Optional in-dwell overrun reporting: STEPMON_OVERRUN_EN.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module stepmotor_monitor
   import stepmotor_pkg::*;
#(
   parameter int TIME_FWD  = DEF_TIME_FWD,
   parameter int TIME_STOP = DEF_TIME_STOP,
   parameter int TIME_REV  = DEF_TIME_REV,
   parameter int TOL       = DEF_TOL
) (
   input  logic       clk1h,
   input  logic       rst,
   input  logic [5:0] dir_in,
   output logic [1:0] mode,
   output logic [5:0] dwell,
   output logic [2:0] err_code,
   output logic       err_sticky,
   output logic [7:0] cycles
);

   state_t     state;
   code_t      code_q;
   code_t      code_new;
   logic       changed;
   logic       checking;
   logic       ovr_flag;
   logic       clean;
   logic       ill_hit;
   logic       ord_bad;
   logic       dur_bad;
   logic       ovr_hit;
   logic       err_now;
   logic       fwd_entry;
   logic       cycle_done;
   logic [2:0] err_val;
   int         t_exp;
   int         dwell_i;

   stepmotor_dwell_cnt u_dwell_cnt (
      .clk1h (clk1h),
      .rst   (rst),
      .load  (changed),
      .dwell (dwell)
   );

   // All checks compare the incoming code with the registered one, so the
   // dwell seen here is the final dwell of the code being left.
   always_comb begin
      code_new = decode_dir(dir_in);
      changed  = (code_new != code_q);
      checking = state inside {ST_FWD, ST_STOP_AF, ST_REV, ST_STOP_AR};
      dwell_i  = int'(dwell);
      case (code_q)
         CODE_FWD: t_exp = TIME_FWD;
         CODE_REV: t_exp = TIME_REV;
         default:  t_exp = TIME_STOP;
      endcase
      ill_hit = changed && (code_new == CODE_ILL);
      ord_bad = changed && checking && !ill_hit && (code_new != expected_next(state));
      dur_bad = changed && checking && !ovr_flag &&
                ((dwell_i < t_exp - TOL) || (dwell_i > t_exp + TOL));
`ifdef STEPMON_OVERRUN_EN
      ovr_hit = !changed && checking && !ovr_flag &&
                (t_exp + TOL < int'(DWELL_MAX)) && (dwell_i == t_exp + TOL);
`else
      ovr_hit = 1'b0;
`endif
      if (ill_hit)      err_val = ERR_ILLEGAL;
      else if (ord_bad) err_val = ERR_ORDER;
      else if (dur_bad) err_val = ERR_DURATION;
      else              err_val = ERR_OVERRUN;
      err_now    = ill_hit || ord_bad || dur_bad || ovr_hit;
      fwd_entry  = changed && (code_new == CODE_FWD) && ((state == ST_SYNC) || checking);
      cycle_done = fwd_entry && (state == ST_STOP_AR) && clean && !err_now;
   end

   always_ff @(posedge clk1h or negedge rst) begin
      if (!rst) begin
         state      <= ST_SYNC;
         mode       <= MODE_SYNC;
         code_q     <= CODE_STOP;
         err_code   <= ERR_NONE;
         err_sticky <= 1'b0;
         cycles     <= 8'd0;
         clean      <= 1'b0;
         ovr_flag   <= 1'b0;
      end else begin
         code_q <= code_new;
         if (changed) begin
            ovr_flag <= 1'b0;
            if (code_new == CODE_ILL) begin
               state <= ST_FAULT;
               mode  <= MODE_SYNC;
            end else begin
               case (state)
                  ST_SYNC: begin
                     if (code_new == CODE_FWD) begin
                        state <= ST_FWD;
                        mode  <= MODE_FWD;
                     end
                  end
                  ST_FAULT: begin
                     if (code_new == CODE_STOP) begin
                        state <= ST_SYNC;
                        mode  <= MODE_SYNC;
                     end
                  end
                  default: begin
                     // Out-of-order codes still resynchronise to the new code.
                     case (code_new)
                        CODE_FWD: begin
                           state <= ST_FWD;
                           mode  <= MODE_FWD;
                        end
                        CODE_REV: begin
                           state <= ST_REV;
                           mode  <= MODE_REV;
                        end
                        default: begin
                           state <= (code_q == CODE_REV) ? ST_STOP_AR : ST_STOP_AF;
                           mode  <= MODE_STOP;
                        end
                     endcase
                  end
               endcase
            end
         end else if (ovr_hit) begin
            ovr_flag <= 1'b1;
         end

         if (err_now) begin
            err_code   <= err_val;
            err_sticky <= 1'b1;
         end
         if (fwd_entry) begin
            clean <= 1'b1;
         end else if (err_now) begin
            clean <= 1'b0;
         end
         if (cycle_done) begin
            cycles <= cycles + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stepmotor_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stepmotor_monitor : scoreboard bench for stepmotor_monitor            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_stepmotor_monitor;

   localparam int T_FWD  = 30;
   localparam int T_STOP = 10;
   localparam int T_REV  = 30;
   localparam int T_TOL  = 0;

   localparam logic [5:0] D_FWD  = 6'b000111;
   localparam logic [5:0] D_STOP = 6'b000000;
   localparam logic [5:0] D_REV  = 6'b111000;
   localparam logic [5:0] D_ILL  = 6'b010101;

`ifdef STEPMON_OVERRUN_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic       clk1h;
   logic       rst;
   logic [5:0] dir_in;
   logic [1:0] mode;
   logic [5:0] dwell;
   logic [2:0] err_code;
   logic       err_sticky;
   logic [7:0] cycles;

   int nerr = 0;
   int nchk = 0;
   string tname = "";

   logic [19:0] sb[$];

   // Reference model: code 0 stop, 1 fwd, 2 rev, 3 illegal.
   // Phase -1 sync, -2 fault, 0 fwd, 1 stop-after-fwd, 2 rev, 3 stop-after-rev.
   int m_code, m_phase, m_dwell, m_err, m_sticky, m_cycles, m_clean, m_ovr;

   stepmotor_monitor #(
      .TIME_FWD  (T_FWD),
      .TIME_STOP (T_STOP),
      .TIME_REV  (T_REV),
      .TOL       (T_TOL)
   ) dut (
      .clk1h      (clk1h),
      .rst        (rst),
      .dir_in     (dir_in),
      .mode       (mode),
      .dwell      (dwell),
      .err_code   (err_code),
      .err_sticky (err_sticky),
      .cycles     (cycles)
   );

   initial clk1h = 1'b0;
   always #5 clk1h = ~clk1h;

   function automatic int dec(input logic [5:0] d);
      if (d == D_FWD)  return 1;
      if (d == D_STOP) return 0;
      if (d == D_REV)  return 2;
      return 3;
   endfunction

   function automatic int tm(input int c);
      if (c == 1) return T_FWD;
      if (c == 2) return T_REV;
      return T_STOP;
   endfunction

   task automatic model_reset();
      m_code = 0; m_phase = -1; m_dwell = 0; m_err = 0;
      m_sticky = 0; m_cycles = 0; m_clean = 0; m_ovr = 0;
      sb.delete();
   endtask

   task automatic model_step(input logic [5:0] d);
      int nc, e, t, nxt, mm;
      bit entry;
      nc = dec(d); e = 0; entry = 0; t = tm(m_code);
      if (nc != m_code) begin
         if (nc == 3) begin
            e = 3;
            m_phase = -2;
         end else if (m_phase == -1) begin
            if (nc == 1) begin m_phase = 0; entry = 1; end
         end else if (m_phase == -2) begin
            if (nc == 0) m_phase = -1;
         end else begin
            nxt = (m_phase == 0 || m_phase == 2) ? 0 : (m_phase == 1) ? 2 : 1;
            if (nc != nxt) e = 2;
            else if (!m_ovr && (m_dwell < t - T_TOL || m_dwell > t + T_TOL)) e = 1;
            if (m_phase == 3 && nc == 1 && m_clean == 1 && e == 0)
               m_cycles = (m_cycles + 1) % 256;
            if (nc == 1) begin m_phase = 0; entry = 1; end
            else if (nc == 2) m_phase = 2;
            else m_phase = (m_code == 2) ? 3 : 1;
         end
         m_dwell = 1;
         m_ovr = 0;
      end else begin
         if (OVR && m_phase >= 0 && !m_ovr && t + T_TOL < 63 && m_dwell == t + T_TOL) begin
            e = 4;
            m_ovr = 1;
         end
         if (m_dwell < 63) m_dwell++;
      end
      if (e != 0) begin m_err = e; m_sticky = 1; end
      if (entry) m_clean = 1;
      else if (e != 0) m_clean = 0;
      m_code = nc;
      mm = (m_phase < 0) ? 0 : (m_phase == 0) ? 1 : (m_phase == 2) ? 3 : 2;
      sb.push_back({2'(mm), 6'(m_dwell), 3'(m_err), 1'(m_sticky), 8'(m_cycles)});
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc(input logic [5:0] d);
      logic [19:0] exp_v;
      dir_in = d;
      model_step(d);
      @(posedge clk1h);
      #1;
      nchk++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL %s sb_empty: got output with no expectation", tname);
      end else begin
         exp_v = sb.pop_front();
         if ({mode, dwell, err_code, err_sticky, cycles} !== exp_v) begin
            nerr++;
            $display("FAIL %s sb t=%0t: got mode=%b dwell=%0d err=%0d sticky=%b cycles=%0d, want mode=%b dwell=%0d err=%0d sticky=%b cycles=%0d",
                     tname, $time, mode, dwell, err_code, err_sticky, cycles,
                     exp_v[19:18], exp_v[17:12], exp_v[11:9], exp_v[8], exp_v[7:0]);
         end
      end
      @(negedge clk1h);
   endtask

   task automatic run(input logic [5:0] d, input int n);
      for (int i = 0; i < n; i++) cyc(d);
   endtask

   task automatic check_reset_vals(input string nm);
      nchk++;
      if ({mode, dwell, err_code, err_sticky, cycles} !== 20'd0) begin
         nerr++;
         $display("FAIL %s: got mode=%b dwell=%0d err=%0d sticky=%b cycles=%0d, want all zero",
                  nm, mode, dwell, err_code, err_sticky, cycles);
      end
   endtask

   task automatic do_reset();
      @(negedge clk1h);
      rst = 1'b0;
      model_reset();
      @(posedge clk1h);
      #1;
      @(negedge clk1h);
      rst = 1'b1;
   endtask

   task automatic full_cycle(input int stop2);
      run(D_FWD, T_FWD); run(D_STOP, T_STOP); run(D_REV, T_REV); run(D_STOP, stop2); cyc(D_FWD);
   endtask

   task automatic test_reset();
      tname = "reset";
      rst = 1'b0;
      dir_in = D_STOP;
      model_reset();
      repeat (2) @(posedge clk1h);
      #1;
      check_reset_vals("reset_values");
      @(negedge clk1h);
      rst = 1'b1;
      run(D_STOP, 3);
   endtask

   task automatic test_clean_cycle();
      logic [1:0] seen [5];
      logic [1:0] want [5];
      want = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
      tname = "clean_cycle";
      do_reset();
      cyc(D_FWD);  seen[0] = mode; run(D_FWD, T_FWD - 1);
      cyc(D_STOP); seen[1] = mode; run(D_STOP, T_STOP - 1);
      cyc(D_REV);  seen[2] = mode; run(D_REV, T_REV - 1);
      cyc(D_STOP); seen[3] = mode; run(D_STOP, T_STOP - 1);
      cyc(D_FWD);  seen[4] = mode;
      for (int i = 0; i < 5; i++) begin
         nchk++;
         if (seen[i] !== want[i]) begin
            nerr++;
            $display("FAIL clean_mode_seq[%0d]: got %b want %b", i, seen[i], want[i]);
         end
      end
      nchk++;
      if (cycles !== 8'd1 || err_sticky !== 1'b0) begin
         nerr++;
         $display("FAIL clean_result: got cycles=%0d sticky=%b want cycles=1 sticky=0", cycles, err_sticky);
      end
   endtask

   task automatic test_duration();
      tname = "duration";
      do_reset();
      run(D_FWD, T_FWD - 1);
      cyc(D_STOP);
      nchk++;
      if (err_code !== 3'd1 || err_sticky !== 1'b1 || cycles !== 8'd0) begin
         nerr++;
         $display("FAIL duration_short: got err=%0d sticky=%b cycles=%0d want err=1 sticky=1 cycles=0",
                  err_code, err_sticky, cycles);
      end
   endtask

   task automatic test_order();
      tname = "order";
      do_reset();
      run(D_FWD, T_FWD); run(D_STOP, T_STOP);
      cyc(D_FWD);
      nchk++;
      if (err_code !== 3'd2 || mode !== 2'b01) begin
         nerr++;
         $display("FAIL order_err: got err=%0d mode=%b want err=2 mode=01", err_code, mode);
      end
      run(D_FWD, T_FWD - 1); run(D_STOP, T_STOP); run(D_REV, T_REV); run(D_STOP, T_STOP); cyc(D_FWD);
      nchk++;
      if (cycles !== 8'd1) begin
         nerr++;
         $display("FAIL order_recover_cycles: got %0d want 1", cycles);
      end
   endtask

   task automatic test_illegal();
      tname = "illegal";
      do_reset();
      run(D_FWD, T_FWD); run(D_STOP, T_STOP); run(D_REV, 10);
      cyc(D_ILL);
      nchk++;
      if (err_code !== 3'd3 || mode !== 2'b00) begin
         nerr++;
         $display("FAIL illegal_err: got err=%0d mode=%b want err=3 mode=00", err_code, mode);
      end
      cyc(D_STOP);
      nchk++;
      if (mode !== 2'b00) begin
         nerr++;
         $display("FAIL illegal_exit_mode: got %b want 00", mode);
      end
      run(D_STOP, 4);
      cyc(D_FWD);
      nchk++;
      if (mode !== 2'b01 || err_code !== 3'd3) begin
         nerr++;
         $display("FAIL illegal_resync: got mode=%b err=%0d want mode=01 err=3", mode, err_code);
      end
   endtask

   task automatic test_overrun();
      tname = "overrun";
      do_reset();
      run(D_FWD, T_FWD);
      cyc(D_FWD);
      nchk++;
      if (dwell !== 6'd31 || err_code !== (OVR ? 3'd4 : 3'd0)) begin
         nerr++;
         $display("FAIL overrun_hold: got dwell=%0d err=%0d want dwell=31 err=%0d",
                  dwell, err_code, OVR ? 4 : 0);
      end
      run(D_FWD, 9);
      cyc(D_STOP);
      nchk++;
      if (err_code !== (OVR ? 3'd4 : 3'd1)) begin
         nerr++;
         $display("FAIL overrun_stop_edge: got err=%0d want %0d", err_code, OVR ? 4 : 1);
      end
   endtask

   task automatic test_back_to_back();
      tname = "back_to_back";
      do_reset();
      cyc(D_FWD); run(D_FWD, T_FWD - 1);
      run(D_STOP, T_STOP); run(D_REV, T_REV); run(D_STOP, T_STOP);
      full_cycle(T_STOP);
      nchk++;
      if (cycles !== 8'd2 || err_sticky !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_cycles: got cycles=%0d sticky=%b want cycles=2 sticky=0", cycles, err_sticky);
      end
   endtask

   task automatic test_stop_long();
      tname = "stop_long";
      do_reset();
      full_cycle(T_STOP + 1);
      nchk++;
      if (cycles !== 8'd0 || err_code !== (OVR ? 3'd4 : 3'd1)) begin
         nerr++;
         $display("FAIL stop_long: got cycles=%0d err=%0d want cycles=0 err=%0d",
                  cycles, err_code, OVR ? 4 : 1);
      end
      run(D_FWD, T_FWD - 1); run(D_STOP, T_STOP); run(D_REV, T_REV); run(D_STOP, T_STOP); cyc(D_FWD);
      nchk++;
      if (cycles !== 8'd1) begin
         nerr++;
         $display("FAIL stop_long_recover: got cycles=%0d want 1", cycles);
      end
   endtask

   task automatic test_saturate_reset();
      tname = "saturate";
      do_reset();
      full_cycle(T_STOP);
      run(D_FWD, 69);
      nchk++;
      if (dwell !== 6'd63 || cycles !== 8'd1) begin
         nerr++;
         $display("FAIL saturate: got dwell=%0d cycles=%0d want dwell=63 cycles=1", dwell, cycles);
      end
      #2 rst = 1'b0;
      #1;
      check_reset_vals("async_reset_values");
      model_reset();
      @(negedge clk1h);
      rst = 1'b1;
      run(D_STOP, 5);
      nchk++;
      if (err_code !== 3'd0 || err_sticky !== 1'b0) begin
         nerr++;
         $display("FAIL resume_no_err: got err=%0d sticky=%b want err=0 sticky=0", err_code, err_sticky);
      end
      full_cycle(T_STOP);
      nchk++;
      if (cycles !== 8'd1 || err_sticky !== 1'b0) begin
         nerr++;
         $display("FAIL resume_cycle: got cycles=%0d sticky=%b want cycles=1 sticky=0", cycles, err_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_clean_cycle();
      test_duration();
      test_order();
      test_illegal();
      test_overrun();
      test_back_to_back();
      test_stop_long();
      test_saturate_reset();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
